// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port MEM-stage data RAM between the pipeline and a debug/loader port.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int unsigned WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pipe_req,
    input  logic        pipe_we,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    output logic [31:0] pipe_rdata,
    output logic        pipe_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] stat_grants,
    output logic [15:0] stat_stalls
`endif
);

    typedef enum logic {StPipe, StDbg} state_t;

    localparam logic [3:0] WaitMax = 4'(WAIT_MAX);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dbg_rdata_d = dbg_rdata_q;
        ram_we      = 1'b0;
        ram_addr    = pipe_addr;
        ram_wdata   = pipe_wdata;
        pipe_stall  = 1'b0;
        dbg_ack     = 1'b0;

        case (state_q)
            StPipe: begin
                ram_we = pipe_req & pipe_we;
                if (dbg_req && (!pipe_req || wait_cnt_q == WaitMax)) begin
                    state_d    = StDbg;
                    wait_cnt_d = 4'd0;
                end else if (!dbg_req) begin
                    wait_cnt_d = 4'd0;
                end else if (pipe_req && wait_cnt_q < WaitMax) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StDbg: begin
                ram_addr    = dbg_addr;
                ram_wdata   = dbg_wdata;
                ram_we      = dbg_we;
                dbg_ack     = 1'b1;
                pipe_stall  = pipe_req;
                dbg_rdata_d = ram_rdata;
                // Always hand the RAM back so the pipeline gets at least one cycle between grants.
                state_d     = StPipe;
                wait_cnt_d  = 4'd0;
            end
        endcase

        // Reset must never let a write or a stall escape, even mid-cycle.
        if (clr) begin
            ram_we     = 1'b0;
            pipe_stall = 1'b0;
            dbg_ack    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= StPipe;
            wait_cnt_q  <= 4'd0;
            dbg_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign pipe_rdata = ram_rdata;
    assign dbg_rdata  = dbg_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_grants_q, stat_grants_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_grants_d = stat_grants_q;
        stat_stalls_d = stat_stalls_q;
        if (dbg_ack && stat_grants_q != 16'hFFFF) begin
            stat_grants_d = stat_grants_q + 16'd1;
        end
        if (pipe_stall && stat_stalls_q != 16'hFFFF) begin
            stat_stalls_d = stat_stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stat_grants_q <= 16'd0;
            stat_stalls_q <= 16'd0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_stalls = stat_stalls_q;
`else
    // Statistics disabled: arbitration is unchanged and no counters exist.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table with a scoreboard queue,
// plus hand-written reset, abort and forced-grant sequences. Uses a 32-word behavioural RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        pipe_req, pipe_we;
    logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        pipe_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_grants, stat_stalls;
`endif

    mem_port_arbiter #(.WAIT_MAX(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .pipe_req   (pipe_req),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_rdata (pipe_rdata),
        .pipe_stall (pipe_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, posedge write; word i preloaded with i.
    logic [31:0] mem [32];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
        end else if (ram_we) begin
            mem[ram_addr[6:2]] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr[6:2]];

    typedef struct {
        logic        pr, pw;
        logic [31:0] pa, pd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        ack, stall, we;
        logic        crd;
        logic [31:0] rd;
        logic        cpr;
        logic [31:0] prd;
    } vec_t;

    typedef struct {
        int          idx;
        logic        ack, stall, we;
        logic        crd;
        logic [31:0] rd;
        logic        cpr;
        logic [31:0] prd;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic pr, logic pw, logic [31:0] pa, logic [31:0] pd,
                                logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
                                logic ack, logic stall, logic we,
                                logic crd, logic [31:0] rd, logic cpr, logic [31:0] prd);
        vec_t v;
        v.pr = pr; v.pw = pw; v.pa = pa; v.pd = pd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ack = ack; v.stall = stall; v.we = we;
        v.crd = crd; v.rd = rd; v.cpr = cpr; v.prd = prd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pr, input logic pw, input logic [31:0] pa,
                         input logic [31:0] pd, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        pipe_req = pr; pipe_we = pw; pipe_addr = pa; pipe_wdata = pd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    initial begin
        int   acks;
        int   stalls;
        int   ack_cyc[3];
        exp_t e;

        // Reset with busy inputs: nothing may leak out while clr is high.
        clr = 1'b1;
        mem_init = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 32'h77, 1'b1, 1'b1, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst ram_we", 32'(ram_we), 32'd0);
        check("rst stall", 32'(pipe_stall), 32'd0);
        check("rst ack", 32'(dbg_ack), 32'd0);
        check("rst dbg_rdata", dbg_rdata, 32'd0);
        mem_init = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Idle pipeline: debug write DEADBEEF to 0x14, then read it back.
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 32'h14, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 32'h14, 32'hDEADBEEF, 1, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 32'h14, 32'h0, 0, 0, 0, 1, 32'd5, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 32'h14, 32'h0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        // Store every cycle with dbg_req held: forced grant in the 6th cycle.
        for (int k = 1; k <= 5; k++) begin
            vt.push_back(mk(1, 1, 32'h40, 32'h100 + 32'(k), 1, 0, 32'h0C, 0,
                            0, 0, 1, 0, 0, 0, 0));
        end
        vt.push_back(mk(1, 1, 32'h40, 32'h200, 1, 0, 32'h0C, 0, 1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 32'h40, 32'h200, 0, 0, 0, 0, 0, 0, 1, 1, 32'd3, 0, 0));
        vt.push_back(mk(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200));
        // Same-cycle pipe load and dbg_req: pipeline wins, debug served once pipe is idle.
        vt.push_back(mk(1, 0, 32'h0C, 0, 1, 0, 32'h08, 0, 0, 0, 0, 0, 0, 1, 32'd3));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 32'h08, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 32'h08, 0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd2, 0, 0));
        // dbg_req held for three accesses on an idle pipeline: acks every other cycle.
        for (int k = 0; k < 6; k++) begin
            vt.push_back(mk(0, 0, 0, 0, 1, 0, 32'h14, 0, logic'(k % 2), 0, 0, 0, 0, 0, 0));
        end
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        // Dropping dbg_req before ack clears the wait count.
        vt.push_back(mk(1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            vt.push_back(mk(1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        vt.push_back(mk(1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            drive(vt[i].pr, vt[i].pw, vt[i].pa, vt[i].pd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
            sb.push_back('{i, vt[i].ack, vt[i].stall, vt[i].we, vt[i].crd, vt[i].rd,
                           vt[i].cpr, vt[i].prd});
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("v%0d dbg_ack", e.idx), 32'(dbg_ack), 32'(e.ack));
            check($sformatf("v%0d pipe_stall", e.idx), 32'(pipe_stall), 32'(e.stall));
            check($sformatf("v%0d ram_we", e.idx), 32'(ram_we), 32'(e.we));
            if (e.crd) check($sformatf("v%0d dbg_rdata", e.idx), dbg_rdata, e.rd);
            if (e.cpr) check($sformatf("v%0d pipe_rdata", e.idx), pipe_rdata, e.prd);
            @(posedge clk);
            #1;
        end

        // clr during the ack cycle of a debug write to 0x08 aborts it.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h08, 32'hBAD0BAD0);
        @(posedge clk);
        #1;
        check("abort pre ack", 32'(dbg_ack), 32'd1);
        check("abort pre ram_we", 32'(ram_we), 32'd1);
        clr = 1'b1;
        #1;
        check("abort ack", 32'(dbg_ack), 32'd0);
        check("abort ram_we", 32'(ram_we), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("abort dbg_rdata", dbg_rdata, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        drive(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("abort word2", pipe_rdata, 32'd2);
        @(posedge clk);
        #1;

        // Continuous stores with dbg_req held: three forced grants, one every 6 cycles.
        acks = 0;
        stalls = 0;
        drive(1'b1, 1'b1, 32'h44, 32'h55, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (pipe_stall) stalls++;
            if (dbg_ack) begin
                ack_cyc[acks] = cyc;
                acks++;
            end
            @(posedge clk);
            #1;
            if (acks == 3) break;
        end
        dbg_req = 1'b0;
        pipe_req = 1'b0;
        check("forced acks", 32'(acks), 32'd3);
        check("forced stalls", 32'(stalls), 32'd3);
        if (acks == 3) begin
            check("forced ack1", 32'(ack_cyc[0]), 32'd6);
            check("forced ack2", 32'(ack_cyc[1]), 32'd12);
            check("forced ack3", 32'(ack_cyc[2]), 32'd18);
        end
`ifdef MEM_ARB_STATS_EN
        @(posedge clk);
        #1;
        check("stat_grants", 32'(stat_grants), 32'd3);
        check("stat_stalls", 32'(stat_stalls), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter for the single-port 32-word data memory in the MEM stage. It shares the memory between the pipeline's MEM-stage access and a debug/loader port, and stalls the pipeline when the debug port holds the memory. The pipeline has priority; a starvation counter guarantees the debug port a slot within a bounded number of cycles. The arbiter sits between the MEM-stage control signals and the RAM write-enable/address/data lines. The RAM itself (combinational read, posedge write) is unchanged.

## Interface
Parameters:
- WAIT_MAX, default 4: consecutive blocked debug-request cycles before debug is forced in. Legal range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- clr  in  1  reset, asynchronous, active-high.
- pipe_req  in  1  MEM stage performs a load or store this cycle.
- pipe_we  in  1  MEM-stage store.
- pipe_addr  in  32  MEM-stage byte address.
- pipe_wdata  in  32  MEM-stage store data.
- pipe_rdata  out  32  load data to the MEM/WB register (combinational from ram_rdata).
- pipe_stall  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers; insert a bubble into MEM/WB.
- dbg_req  in  1  debug access request, held until dbg_ack.
- dbg_we  in  1  debug write.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_ack  out  1  one-cycle pulse: the debug access occurs this cycle.
- dbg_rdata  out  32  registered read data, valid from the cycle after dbg_ack until the next ack.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM byte address (RAM uses bits [6:2]).
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM combinational read data.

## Operation
- There are two states: S_PIPE (reset state) and S_DBG.
- In S_PIPE:
  - ram_addr/ram_wdata come from pipe_*.
  - ram_we = pipe_req & pipe_we.
  - pipe_stall = 0 and dbg_ack = 0.
- In S_DBG:
  - ram_* come from dbg_*, and ram_we = dbg_we.
  - dbg_ack = 1 and pipe_stall = pipe_req.
  - dbg_rdata <= ram_rdata at the end of the cycle.
- Transition S_PIPE -> S_DBG when dbg_req & (~pipe_req | wait_cnt == WAIT_MAX).
- S_DBG always returns to S_PIPE after one cycle. Back-to-back debug accesses therefore get at least one S_PIPE cycle between them, so the pipeline is never starved.
- wait_cnt (4-bit) behaviour in S_PIPE:
  - Increments when dbg_req & pipe_req.
  - Clears when dbg_req = 0.
  - Saturates at WAIT_MAX.
  - Clears on entry to S_DBG.
- pipe_rdata = ram_rdata in all states. It is ignored while stalled.
- Addresses are passed through unmodified. Aliasing above word 31 is the RAM's behaviour and is not checked here.

## Timing
- Reset values: state S_PIPE, wait_cnt 0, dbg_ack 0, dbg_rdata 0, pipe_stall 0, ram_we 0.
- While clr = 1, ram_we and pipe_stall are forced to 0.
- Reset during S_DBG aborts the access with no write and no ack.
- Debug latency is measured from the first cycle dbg_req is sampled high at a posedge:
  - Pipeline idle: ack in the next cycle.
  - Pipeline continuously busy: ack after WAIT_MAX+1 cycles.
- The debug write commits at the posedge that ends the ack cycle. Read data appears on dbg_rdata one cycle after ack.
- A stall lasts exactly one cycle per debug grant.
- When dbg_req and pipe_req rise in the same cycle with wait_cnt < WAIT_MAX, the pipeline wins.
- Dropping dbg_req before ack cancels the request and clears wait_cnt.

## Configuration
- MEM_ARB_STATS_EN defined:
  - Adds outputs stat_grants (16-bit, count of dbg_ack cycles) and stat_stalls (16-bit, count of cycles with pipe_stall = 1).
  - Both counters saturate at 16'hFFFF and reset to 0 on clr.
- MEM_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Pipeline idle; debug write 32'hDEADBEEF to addr 32'h14 -> ack in the cycle after req; a following debug read of 0x14 returns 32'hDEADBEEF on dbg_rdata one cycle after its ack.
- Pipeline store every cycle with WAIT_MAX = 4 and dbg_req held -> ack in the 6th cycle; pipe_stall high only in that cycle; the store held during the stall commits the next cycle.
- dbg_req held for 3 accesses with pipeline idle -> acks spaced two cycles apart, with S_PIPE between each.
- clr asserted during the ack cycle of a debug write to 0x08 -> RAM word 2 keeps its value (2); dbg_ack and ram_we drop immediately.
- Simultaneous first-cycle pipe load from 0x0C and dbg_req -> pipeline reads 3 with no stall; debug is served on the first subsequent cycle without pipe_req.
- With MEM_ARB_STATS_EN, 3 forced grants -> stat_grants = 3 and stat_stalls = 3.
